sample_disassembler: RTL and testbench

- Transmit-side counterpart to the capture path's byte assembly.
- Accepts 16-bit audio samples over a valid/ready handshake and buffers them in a small internal FIFO.
- Serializes each sample into two 8-bit bytes on a valid/ready byte stream, for example toward a UART/SPI transmitter.
- Default byte order is low byte first, matching the order in which the receive path rebuilds samples as {second, first}.

---
 rtl/sample_disassembler.sv | 123 ++++++++++++
 tb/tb_sample_disassembler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_disassembler.sv
// Splits buffered 16-bit samples into two bytes on a valid/ready byte stream.
// A small FIFO decouples the sample producer from the byte consumer.
module sample_disassembler #(
  parameter int FIFO_DEPTH = 4,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [15:0]                 sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic [7:0]                  byte_out,
  output logic                        byte_valid,
  input  logic                        byte_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_e;

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q;
  logic [15:0]      hold_q;
  logic [7:0]       byte_q;
  logic             byte_valid_q;

  logic        push, pop, fifo_nonempty;
  logic [15:0] head;

  function automatic logic [7:0] first_byte(input logic [15:0] s);
    return LSB_FIRST ? s[7:0] : s[15:8];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] s);
    return LSB_FIRST ? s[15:8] : s[7:0];
  endfunction

  // Ready depends only on the registered count, so a same-cycle pop never frees a full FIFO.
  assign fifo_nonempty = (count_q != '0);
  assign sample_ready  = (count_q < DEPTH_C);
  assign push          = sample_valid && sample_ready && !flush && !rst;
  assign pop           = fifo_nonempty &&
                         ((state_q == IDLE) || ((state_q == SECOND) && byte_ready));
  assign head          = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sample storage is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      hold_q       <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (pop) begin
            hold_q       <= head;
            byte_q       <= first_byte(head);
            byte_valid_q <= 1'b1;
            state_q      <= FIRST;
          end
        end
        FIRST: begin
          if (byte_ready) begin
            byte_q  <= second_byte(hold_q);
            state_q <= SECOND;
          end
        end
        SECOND: begin
          if (byte_ready) begin
            if (pop) begin
              hold_q  <= head;
              byte_q  <= first_byte(head);
              state_q <= FIRST;
            end else begin
              byte_valid_q <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end
        default: begin
          byte_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_sample_disassembler.sv
// Randomized and directed bench for sample_disassembler; a byte-queue scoreboard
// is filled on accepted samples and drained by a monitor on accepted bytes.
module tb_sample_disassembler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic        busy;

  // Second instance with high byte first
  logic [15:0] sample_in2 = '0;
  logic        sample_valid2 = 1'b0;
  logic        sample_ready2;
  logic [7:0]  byte_out2;
  logic        byte_valid2;
  logic [2:0]  fifo_count2;
  logic        busy2;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_out = '0;

  sample_disassembler #(.FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .fifo_count(fifo_count), .busy(busy)
  );

  sample_disassembler #(.FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .flush(1'b0),
    .sample_in(sample_in2), .sample_valid(sample_valid2), .sample_ready(sample_ready2),
    .byte_out(byte_out2), .byte_valid(byte_valid2), .byte_ready(1'b1),
    .fifo_count(fifo_count2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    byte_ready   = 1'b1;
    sample_valid = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check(name, busy, 0);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: byte transfers are popped from the scoreboard, accepted samples pushed.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (prev_stall) begin
        check("stall_valid", byte_valid, 1);
        check("stall_out", byte_out, prev_out);
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte actual=%0h required=none", byte_out);
        end else begin
          check("byte_stream", byte_out, exp_q.pop_front());
        end
      end
      if (sample_valid && sample_ready) begin
        exp_q.push_back(sample_in[7:0]);
        exp_q.push_back(sample_in[15:8]);
      end
    end
    prev_stall = !(rst || flush) && byte_valid && !byte_ready;
    prev_out   = byte_out;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  got[$];
    logic        acc;
    int          n_acc;

    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", byte_valid, 0);
    check("rst_out", byte_out, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", sample_ready, 1);

    // High-byte-first instance
    sample_valid2 = 1'b1;
    sample_in2    = 16'h1234;
    tick();
    sample_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (byte_valid2) got.push_back(byte_out2);
      tick();
    end
    check("msb_nbytes", got.size(), 2);
    if (got.size() == 2) begin
      check("msb_first", got[0], 8'h12);
      check("msb_second", got[1], 8'h34);
    end

    // Single sample, low byte first, latency
    byte_ready   = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 16'hA55A;
    tick();
    sample_valid = 1'b0;
    check("lat_not_yet", byte_valid, 0);
    tick();
    check("lat_valid", byte_valid, 1);
    check("single_lo", byte_out, 8'h5A);
    tick();
    check("single_hi_valid", byte_valid, 1);
    check("single_hi", byte_out, 8'hA5);
    tick();
    check("single_done_valid", byte_valid, 0);
    check("single_done_busy", busy, 0);

    // Backpressure
    byte_ready   = 1'b0;
    sample_valid = 1'b1;
    sample_in    = 16'hBEEF;
    tick();
    sample_valid = 1'b0;
    tick();
    check("bp_valid", byte_valid, 1);
    check("bp_out", byte_out, 8'hEF);
    repeat (5) tick();
    check("bp_hold", byte_out, 8'hEF);
    byte_ready = 1'b1;
    tick();
    check("bp_second", byte_out, 8'hBE);
    tick();
    check("bp_done", byte_valid, 0);

    // Full FIFO: one sample held, four queued, the sixth refused until space frees
    byte_ready   = 1'b0;
    sample_valid = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      sample_in = 16'(v);
      tick();
    end
    sample_in = 16'h0006;
    check("full_count", fifo_count, 4);
    check("full_ready", sample_ready, 0);
    check("full_head", byte_out, 8'h01);
    tick();
    check("full_hold_count", fifo_count, 4);
    byte_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("full_nogap", byte_valid, 1);
      acc = sample_valid && sample_ready;
      tick();
      if (acc) sample_valid = 1'b0;
    end
    check("full_sixth_taken", sample_valid, 0);
    check("full_end_valid", byte_valid, 0);
    drain("full_drain");

    // Simultaneous push and pop at count 2
    byte_ready   = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_in = 16'($urandom);
      tick();
    end
    sample_valid = 1'b0;
    check("pp_count_a", fifo_count, 2);
    byte_ready = 1'b1;
    tick();
    check("pp_count_b", fifo_count, 2);
    sample_valid = 1'b1;
    sample_in    = 16'($urandom);
    tick();
    sample_valid = 1'b0;
    check("pp_count_c", fifo_count, 2);
    drain("pp_drain");

    // Random traffic with random backpressure, exercising pointer wrap
    n_acc = 0;
    sample_valid = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      acc = sample_valid && sample_ready;
      tick();
      if (acc) n_acc++;
      if (!sample_valid || acc) begin
        sample_valid = 1'($urandom_range(0, 1));
        sample_in    = 16'($urandom);
      end
      byte_ready = ($urandom_range(0, 3) != 0);
    end
    check("rand_wrap_cover", (n_acc >= 3 * DEPTH), 1);
    drain("rand_drain");

    // Reset in SECOND with samples queued
    byte_ready   = 1'b0;
    sample_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sample_in = 16'(i * 16'h1111);
      tick();
    end
    sample_valid = 1'b0;
    byte_ready   = 1'b1;
    tick();
    byte_ready = 1'b0;
    check("pre_rst_count", fifo_count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", byte_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_busy", busy, 0);
    byte_ready = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_quiet", byte_valid, 0);
    end

    // Flush in SECOND with a concurrent push that must be dropped
    byte_ready   = 1'b0;
    sample_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sample_in = 16'(i * 16'h0101);
      tick();
    end
    sample_valid = 1'b0;
    byte_ready   = 1'b1;
    tick();
    byte_ready = 1'b0;
    check("pre_flush_count", fifo_count, 3);
    flush        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 16'hDEAD;
    tick();
    flush        = 1'b0;
    sample_valid = 1'b0;
    check("flush_valid", byte_valid, 0);
    check("flush_count", fifo_count, 0);
    check("flush_busy", busy, 0);
    byte_ready = 1'b1;
    repeat (3) begin
      tick();
      check("post_flush_quiet", byte_valid, 0);
      check("post_flush_busy", busy, 0);
    end

    check("final_sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
